// File: rtl/bp_table_ctrl_pkg.sv
// Shared types and helpers for the branch-direction table controller.
// Holds the controller FSM encoding, the update-queue entry layout and
// the saturating-counter arithmetic used by the read-modify-write path.
package bp_pkg;

  // Default geometry of the direction table.
  localparam int unsigned BP_IDX_W     = 6;
  localparam int unsigned BP_CNT_W     = 2;
  // Queue entries carry a fixed-width index; the controller uses the low IDX_W bits.
  localparam int unsigned BP_IDX_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } bp_state_e;

  typedef struct packed {
    logic [BP_IDX_MAX_W-1:0] idx;
    logic                    taken;
  } upd_entry_t;

  // Largest value a w-bit counter can hold.
  function automatic logic [7:0] cnt_max(input int unsigned w);
    return 8'((32'd1 << w) - 32'd1);
  endfunction

  localparam logic [7:0] BP_CNT_MAX = cnt_max(BP_CNT_W);

  // Saturating step: taken moves toward max_v, not-taken moves toward zero.
  function automatic logic [7:0] sat_next(input logic [7:0] v,
                                          input logic       taken,
                                          input logic [7:0] max_v);
    logic [7:0] r;
    if (taken) begin
      if (v >= max_v) begin
        r = max_v;
      end else begin
        r = v + 8'd1;
      end
    end else begin
      if (v == 8'd0) begin
        r = 8'd0;
      end else begin
        r = v - 8'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_table_ctrl_upd_fifo.sv
// Update queue for resolved branches: a small circular FIFO with
// registered full/empty. The owner never pushes when full nor pops when empty.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output upd_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  upd_entry_t       mem_q [DEPTH];
  upd_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state registers; reset discards all pending updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch-direction table controller: 2^IDX_W saturating counters behind a
// single read / single write port. Lookups and queued read-modify-write
// updates share the read port; a starvation limit guarantees update progress.
// Optional macro GSHARE_HIST_EN: XOR the lookup index with a global history
// register shifted on every accepted update (default build is bimodal).
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = BP_IDX_W,
  parameter int unsigned CNT_W      = BP_CNT_W,
  parameter int unsigned UQ_DEPTH   = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid_i,
  output logic             lk_ready_o,
  input  logic [31:0]      lk_pc_i,
  output logic             pred_valid_o,
  output logic             pred_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             busy_o
);

  localparam int unsigned TBL_N = 1 << IDX_W;
  localparam int unsigned ST_W  = $clog2(STARVE_LIM + 1);
  localparam logic [7:0]  CNT_MAX = (CNT_W == BP_CNT_W) ? BP_CNT_MAX : cnt_max(CNT_W);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic [CNT_W-1:0] old_q, old_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_q, pred_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [CNT_W-1:0] table_q [TBL_N];
  logic [CNT_W-1:0] table_d [TBL_N];

  upd_entry_t       fifo_din_s, head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic             push_s, pop_s;
  logic [IDX_W-1:0] lk_idx_s, head_idx_s, wr_idx_s;
  logic [CNT_W-1:0] new_val_s, wr_data_s, lk_rd_val_s;
  logic             lk_ready_s, lk_grant_s, upd_rd_s, wr_en_s;
  logic             unused_s;

`ifdef GSHARE_HIST_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // Global history shifts in each accepted outcome.
  always_comb begin
    if (push_s) begin
      ghr_d = {ghr_q[IDX_W-2:0], upd_taken_i};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // History register; cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign lk_idx_s = lk_pc_i[IDX_W+1:2] ^ ghr_q;
`else
  assign lk_idx_s = lk_pc_i[IDX_W+1:2];
`endif

  assign unused_s = ^{lk_pc_i, head_s};

  // Read port goes to lookups unless the pending update has waited too long.
  assign lk_ready_s = (state_q != ST_INIT) &&
                      !(!fifo_empty_s && (starve_q == ST_W'(STARVE_LIM)));
  assign lk_grant_s = lk_valid_i && lk_ready_s;
  assign push_s     = upd_valid_i && upd_ready_o;
  assign pop_s      = (state_q == ST_UPD_WR);
  assign fifo_din_s = '{idx: BP_IDX_MAX_W'(upd_idx_i), taken: upd_taken_i};
  assign head_idx_s = head_s.idx[IDX_W-1:0];
  assign new_val_s  = CNT_W'(sat_next(8'(old_q), head_s.taken, CNT_MAX));

  bp_upd_fifo #(
    .DEPTH (UQ_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .din_i   (fifo_din_s),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Controller FSM: init sweep, read arbitration and update write-back.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    old_d     = old_q;
    upd_rd_s  = 1'b0;
    wr_en_s   = 1'b0;
    wr_idx_s  = '0;
    wr_data_s = '0;
    case (state_q)
      ST_INIT: begin
        wr_en_s  = 1'b1;
        wr_idx_s = ptr_q;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(TBL_N - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (lk_grant_s) begin
          state_d = ST_IDLE;
        end else if (!fifo_empty_s) begin
          upd_rd_s = 1'b1;
          old_d    = table_q[head_idx_s];
          state_d  = ST_UPD_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPD_WR: begin
        wr_en_s   = 1'b1;
        wr_idx_s  = head_idx_s;
        wr_data_s = new_val_s;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Lookup read with bypass from a same-cycle write-back to the same entry.
  always_comb begin
    lk_rd_val_s = table_q[lk_idx_s];
    if ((state_q == ST_UPD_WR) && (head_idx_s == lk_idx_s)) begin
      lk_rd_val_s = new_val_s;
    end else begin
      lk_rd_val_s = table_q[lk_idx_s];
    end
  end

  // Prediction outputs: one-cycle valid pulse, index and direction held.
  always_comb begin
    pred_valid_d = 1'b0;
    pred_d       = pred_q;
    pred_idx_d   = pred_idx_q;
    if (lk_grant_s) begin
      pred_valid_d = 1'b1;
      pred_d       = lk_rd_val_s[CNT_W-1];
      pred_idx_d   = lk_idx_s;
    end else begin
      pred_valid_d = 1'b0;
    end
  end

  // Starvation counter: lookup grants counted while an update is waiting.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty_s || upd_rd_s) begin
      starve_d = '0;
    end else if (lk_grant_s) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Table write port: sweep clears or saturating write-back.
  always_comb begin
    table_d = table_q;
    if (wr_en_s) begin
      table_d[wr_idx_s] = wr_data_s;
    end else begin
      table_d = table_q;
    end
  end

  // Counter storage; contents are cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      starve_q     <= '0;
      old_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_q       <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      starve_q     <= starve_d;
      old_q        <= old_d;
      pred_valid_q <= pred_valid_d;
      pred_q       <= pred_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign lk_ready_o   = lk_ready_s;
  assign upd_ready_o  = (state_q != ST_INIT) && !fifo_full_s;
  assign busy_o       = (state_q == ST_INIT);
  assign pred_valid_o = pred_valid_q;
  assign pred_o       = pred_q;
  assign pred_idx_o   = pred_idx_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: directed scenarios plus randomized
// lookups/updates checked against an array-of-integers counter model.
module tb_bp_table_ctrl;

  localparam int IDX_W = 6;
  localparam int N     = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             lk_valid_i = 1'b0;
  logic             lk_ready_o;
  logic [31:0]      lk_pc_i = '0;
  logic             pred_valid_o;
  logic             pred_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i = 1'b0;
  logic             upd_ready_o;
  logic [IDX_W-1:0] upd_idx_i = '0;
  logic             upd_taken_i = 1'b0;
  logic             busy_o;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               tbl_m [N];
  logic [IDX_W-1:0] ghr_m = '0;

  bp_table_ctrl #(
    .IDX_W      (6),
    .CNT_W      (2),
    .UQ_DEPTH   (2),
    .STARVE_LIM (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lk_valid_i   (lk_valid_i),
    .lk_ready_o   (lk_ready_o),
    .lk_pc_i      (lk_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_o       (pred_o),
    .pred_idx_o   (pred_idx_o),
    .upd_valid_i  (upd_valid_i),
    .upd_ready_o  (upd_ready_o),
    .upd_idx_i    (upd_idx_i),
    .upd_taken_i  (upd_taken_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input bit t);
    if (t) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic void model_upd(input int idx, input bit t);
    tbl_m[idx] = sat(tbl_m[idx], t);
`ifdef GSHARE_HIST_EN
    ghr_m = {ghr_m[IDX_W-2:0], t};
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) tbl_m[i] = 0;
    ghr_m = '0;
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    logic [31:0] pc;
    pc = $urandom;
    pc[IDX_W+1:2] = IDX_W'(idx) ^ ghr_m;
    return pc;
  endfunction

  // Present one update, wait for acceptance, optionally let it retire.
  task automatic do_upd(input int idx, input bit t, input bit drain);
    int n = 0;
    upd_valid_i = 1'b1;
    upd_idx_i   = IDX_W'(idx);
    upd_taken_i = t;
    while (!upd_ready_o && n < 50) begin tick(); n++; end
    check_eq("upd_ready_wait", 32'(upd_ready_o), 32'd1);
    tick();
    upd_valid_i = 1'b0;
    model_upd(idx, t);
    if (drain) repeat (3) tick();
  endtask

  // Look up a table index and compare the prediction with the model.
  task automatic do_lk(input int idx, input string tag);
    int n = 0;
    lk_pc_i    = pc_for(idx);
    lk_valid_i = 1'b1;
    while (!lk_ready_o && n < 50) begin tick(); n++; end
    check_eq("lk_ready_wait", 32'(lk_ready_o), 32'd1);
    tick();
    lk_valid_i = 1'b0;
    check_eq({tag, "_vld"}, 32'(pred_valid_o), 32'd1);
    check_eq({tag, "_idx"}, 32'(pred_idx_o), 32'(idx));
    check_eq({tag, "_pred"}, 32'(pred_o), 32'(tbl_m[idx] >= 2));
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy_o && n < 200) begin n++; tick(); end
    check_eq(tag, 32'(n), 32'd64);
  endtask

  initial begin
    int n;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy_o), 32'd1);
    check_eq("rst_lk_ready", 32'(lk_ready_o), 32'd0);
    check_eq("rst_upd_ready", 32'(upd_ready_o), 32'd0);
    check_eq("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    check_eq("rst_pred", 32'(pred_o), 32'd0);
    check_eq("rst_pred_idx", 32'(pred_idx_o), 32'd0);
    reset = 1'b1;
    count_busy("init_busy_len");
    check_eq("post_init_lk_ready", 32'(lk_ready_o), 32'd1);
    check_eq("post_init_upd_ready", 32'(upd_ready_o), 32'd1);

    // First lookup at pc 0x100.
    lk_pc_i    = 32'h0000_0100;
    lk_valid_i = 1'b1;
    tick();
    lk_valid_i = 1'b0;
    check_eq("first_vld", 32'(pred_valid_o), 32'd1);
    check_eq("first_pred", 32'(pred_o), 32'd0);
    check_eq("first_idx", 32'(pred_idx_o), 32'd0);
    tick();
    check_eq("pred_pulse", 32'(pred_valid_o), 32'd0);

    // Saturate idx 5 upward, then back down.
    for (int i = 0; i < 4; i++) begin
      do_upd(5, 1'b1, 1'b1);
      do_lk(5, "sat_up");
    end
    for (int i = 0; i < 3; i++) begin
      do_upd(5, 1'b0, 1'b1);
      do_lk(5, "sat_dn");
    end
    check_eq("sat_dn_model_zero", 32'(pred_o), 32'd0);

    // Starvation limit with continuous lookups and one queued update.
    lk_pc_i     = $urandom;
    lk_valid_i  = 1'b1;
    upd_valid_i = 1'b1;
    upd_idx_i   = 6'd3;
    upd_taken_i = 1'b1;
    check_eq("starve_upd_ready", 32'(upd_ready_o), 32'd1);
    tick();
    upd_valid_i = 1'b0;
    model_upd(3, 1'b1);
    n = 0;
    while (lk_ready_o && n < 20) begin n++; tick(); end
    check_eq("starve_grants", 32'(n), 32'd4);
    tick();
    check_eq("starve_release", 32'(lk_ready_o), 32'd1);
    lk_valid_i = 1'b0;
    repeat (4) tick();
    do_lk(3, "starve_applied");

    // Bypass: counter at idx 7 set to 1, then lookup during its 1->2 write.
    for (int i = 0; i < 3; i++) do_upd(7, 1'b0, 1'b1);
    do_upd(7, 1'b1, 1'b1);
    do_lk(7, "byp_pre");
    do_upd(7, 1'b1, 1'b0);
    tick();
    lk_pc_i    = pc_for(7);
    lk_valid_i = 1'b1;
    check_eq("byp_lk_ready", 32'(lk_ready_o), 32'd1);
    tick();
    lk_valid_i = 1'b0;
    check_eq("byp_vld", 32'(pred_valid_o), 32'd1);
    check_eq("byp_pred", 32'(pred_o), 32'd1);
    repeat (3) tick();

    // Queue full while lookups hold the read port.
    lk_pc_i    = $urandom;
    lk_valid_i = 1'b1;
    do_upd(9, 1'b1, 1'b0);
    do_upd(9, 1'b1, 1'b0);
    upd_valid_i = 1'b1;
    upd_idx_i   = 6'd9;
    upd_taken_i = 1'b0;
    check_eq("full_ready_low", 32'(upd_ready_o), 32'd0);
    n = 0;
    while (!upd_ready_o && n < 50) begin tick(); n++; end
    check_eq("full_wait_cycles", 32'(n), 32'd5);
    tick();
    upd_valid_i = 1'b0;
    lk_valid_i  = 1'b0;
    model_upd(9, 1'b0);
    repeat (8) tick();
    do_lk(9, "full_applied");

    // Randomized traffic over a small index window to force collisions.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_upd(int'($urandom_range(0, 7)), 1'($urandom), 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        do_lk(int'($urandom_range(0, N - 1)), "rnd_wide");
      end else begin
        do_lk(int'($urandom_range(0, 7)), "rnd");
      end
    end

    // Reset in the middle of a write-back.
    do_upd(2, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy_o), 32'd1);
    check_eq("mid_rst_lk_ready", 32'(lk_ready_o), 32'd0);
    check_eq("mid_rst_upd_ready", 32'(upd_ready_o), 32'd0);
    check_eq("mid_rst_pred_valid", 32'(pred_valid_o), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    model_clear();
    count_busy("resweep_busy_len");
    check_eq("resweep_upd_ready", 32'(upd_ready_o), 32'd1);
    for (int i = 0; i < N; i++) do_lk(i, "resweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Controller for a table of 2^IDX_W two-bit saturating branch-direction counters held in a single-read/single-write register array.
- Arbitrates the one read port between front-end prediction lookups and back-end resolution updates; updates are read-modify-write.
- Clears the table after reset and provides same-index bypass.
- Sits between fetch (lookup) and the branch resolve stage (update).

Parameters:
- IDX_W, 6, table index width; table holds 2^IDX_W counters.
- CNT_W, 2, counter width; prediction = counter MSB.
- UQ_DEPTH, 2, update queue depth (power of 2, ≥2).
- STARVE_LIM, 4, consecutive lookup grants tolerated while the queue is non-empty.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_valid_i  in  1  lookup request.
- lk_ready_o  out  1  lookup accepted when valid&ready.
- lk_pc_i  in  32  branch PC; word index = pc[IDX_W+1:2].
- pred_valid_o  out  1  prediction valid, 1 cycle after lookup accept.
- pred_o  out  1  predicted taken.
- pred_idx_o  out  IDX_W  table index used; caller returns it on update.
- upd_valid_i  in  1  resolved-branch update request.
- upd_ready_o  out  1  queue not full and not in INIT.
- upd_idx_i  in  IDX_W  index from the earlier pred_idx_o.
- upd_taken_i  in  1  actual outcome.
- busy_o  out  1  high during INIT sweep.

Behaviour:
- Reset (async, reset=0):
  - FSM→INIT; sweep pointer=0; queue empty; starve count=0.
  - pred_valid_o=0, pred_o=0, pred_idx_o=0, busy_o=1, lk_ready_o=0, upd_ready_o=0.
  - Table contents are not reset directly; the sweep clears them.
- INIT:
  - Writes 0 to entry[ptr] each cycle, ptr++.
  - After writing entry 2^IDX_W-1 → IDLE; takes exactly 2^IDX_W cycles.
  - lk_ready_o=0 and upd_ready_o=0 throughout.
- States IDLE, UPD_WR. Per cycle in IDLE:
  - If lk_valid_i and lk_ready_o: read port → lookup.
  - Else if queue non-empty: read port → head entry; latch old value; → UPD_WR.
- UPD_WR:
  - Writes saturating next value: taken → min(v+1, 2^CNT_W-1); not taken → max(v-1, 0).
  - Pops queue → IDLE.
  - The read port remains free, so a lookup may be served in the same cycle.
- lk_ready_o = (state≠INIT) and not (queue non-empty and starve_cnt==STARVE_LIM).
- starve_cnt:
  - Increments on each lookup grant while the queue is non-empty.
  - Clears when an update read is granted or the queue is empty.
- Lookup latency 1:
  - Index computed and registered at accept.
  - pred_o = MSB of the registered read value; pred_valid_o is a 1-cycle pulse.
- Bypass: a lookup read in the same cycle as an UPD_WR to the same index returns the new (written) value.
- Update enqueue:
  - Accepted when upd_valid_i & upd_ready_o.
  - A full queue deasserts upd_ready_o; the caller holds its request.
  - Simultaneous enqueue and pop when full is not allowed: ready is based on registered full.
- Queue ordering: entries retire in FIFO order.
  - Two queued updates to the same index both apply sequentially.
  - The second update reads after the first write completes, because the read occurs in IDLE after UPD_WR.
- Reset asserted mid-operation:
  - Aborts any UPD_WR and discards the queue; an in-flight prediction is dropped.
  - Re-sweeps the table.

Optional Feature:
- GSHARE_HIST_EN defined:
  - IDX_W-bit global history register, reset 0.
  - Index = pc[IDX_W+1:2] XOR ghr.
  - ghr = {ghr[IDX_W-2:0], upd_taken_i} on each accepted update.
- Undefined:
  - Bimodal: index = pc[IDX_W+1:2]; no history register.

Decomposition:
- Package bp_pkg holds:
  - FSM state enum (INIT, IDLE, UPD_WR).
  - Update-queue entry struct {idx, taken}.
  - Counter max constant.
  - Saturating next-value function.
- One natural sub-module: bp_upd_fifo (parameterized UQ_DEPTH queue with full/empty).

Test Plan:
- Reset then idle: busy_o high for exactly 64 cycles, then lk_ready_o=1; lookup at pc=0x100 → pred_o=0 next cycle, pred_idx_o=0x00.
- Four taken updates to idx 5:
  - Counter goes 0→1→2→3→3 (saturates).
  - Lookup idx 5 → pred_o=1.
  - Then three not-taken updates → counter 0, pred_o=0.
- Continuous lookups with 1 queued update: after 4 grants lk_ready_o drops for one cycle and the update read is granted.
- Lookup idx 7 in the same cycle as UPD_WR to idx 7 (1→2): pred_o=1 via bypass.
- Queue full (2 entries) with lookups stalled: upd_ready_o=0 until the first pop; a third update is accepted only after the pop.
- Reset pulsed during UPD_WR: queue empties, busy_o reasserts, all entries read 0 after the sweep. With GSHARE_HIST_EN, the ghr also returns to 0.
